// File: rtl/sliding_window_border_pkg.sv
// Shared definitions for the bordered sliding-window generator: border modes,
// FSM state encoding and a width helper.
package sliding_window_border_pkg;

  localparam logic [1:0] BM_NONE = 2'd0;
  localparam logic [1:0] BM_ZERO = 2'd1;
  localparam logic [1:0] BM_REPL = 2'd2;
  localparam logic [1:0] BM_MIRR = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } state_e;

  // Ceiling log2, never below 1 so it can size any counter or index.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/row_buffers_param.sv
// (MASK_WIDTH-1)-line circular row store. Emits one window column per advance:
// the stored lines at the current column (oldest first) followed by din.
module row_buffers_param
  import sliding_window_border_pkg::*;
#(
  parameter int unsigned ROW_WIDTH  = 100,
  parameter int unsigned PIX_BIT    = 8,
  parameter int unsigned MASK_WIDTH = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          restart,
  input  logic                          adv,
  input  logic                          we,
  input  logic [PIX_BIT-1:0]            din,
  output logic [MASK_WIDTH*PIX_BIT-1:0] col_pix
);

  localparam int unsigned Lines = MASK_WIDTH - 1;
  localparam int unsigned AddrW = clog2(ROW_WIDTH);
  localparam int unsigned PtrW  = clog2(Lines);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(ROW_WIDTH - 1);
  localparam logic [PtrW-1:0]  LastPtr  = PtrW'(Lines - 1);

  logic [PIX_BIT-1:0] mem [Lines][ROW_WIDTH];
  logic [AddrW-1:0]   col_q, addr;
  logic [PtrW-1:0]    ptr_q, ptr;

  // ptr names the line holding the oldest row; it is overwritten by the newest.
  always_comb begin
    addr = restart ? '0 : col_q;
    ptr  = restart ? '0 : ptr_q;
    for (int k = 0; k < int'(Lines); k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= int'(Lines)) idx = idx - int'(Lines);
      col_pix[k*PIX_BIT +: PIX_BIT] = mem[PtrW'(idx)][addr];
    end
    col_pix[Lines*PIX_BIT +: PIX_BIT] = din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      ptr_q <= '0;
    end else if (adv) begin
      if (addr == LastAddr) begin
        col_q <= '0;
        ptr_q <= (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
      end else begin
        col_q <= addr + AddrW'(1);
        ptr_q <= ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[ptr][addr] <= din;
  end

endmodule

// File: rtl/sliding_window_border.sv
// NxN sliding window over a raster frame with selectable border handling
// (none, zero, replicate, mirror), valid/ready input and centre coordinates.
module sliding_window_border
  import sliding_window_border_pkg::*;
#(
  parameter int unsigned ROW_WIDTH  = 100,
  parameter int unsigned COL_HEIGHT = 100,
  parameter int unsigned PIX_BIT    = 8,
  parameter int unsigned MASK_WIDTH = 7
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [1:0]                               border_mode,
  input  logic                                     sof,
  input  logic                                     pix_in_valid,
  input  logic [PIX_BIT-1:0]                       pix_in,
  output logic                                     pix_in_ready,
  output logic                                     win_valid,
  output logic [PIX_BIT*MASK_WIDTH*MASK_WIDTH-1:0] win_pix,
  output logic [clog2(COL_HEIGHT)-1:0]             win_row,
  output logic [clog2(ROW_WIDTH)-1:0]              win_col,
  output logic                                     frame_done
);

  localparam int          H     = int'(MASK_WIDTH - 1) / 2;
  localparam int          NRows = int'(COL_HEIGHT);
  localparam int          NCols = int'(ROW_WIDTH);
  localparam int unsigned RowW  = clog2(COL_HEIGHT);
  localparam int unsigned ColW  = clog2(ROW_WIDTH);
  localparam int unsigned VrW   = clog2(COL_HEIGHT + MASK_WIDTH);
  localparam int unsigned VcW   = clog2(ROW_WIDTH + MASK_WIDTH);
  localparam int unsigned IdxW  = clog2(MASK_WIDTH);
  localparam int unsigned WinW  = PIX_BIT * MASK_WIDTH * MASK_WIDTH;

  localparam logic [VrW-1:0] LastRow    = VrW'(NRows - 1);
  localparam logic [VrW-1:0] LastRowPad = VrW'(NRows - 1 + H);
  localparam logic [VrW-1:0] NumRows    = VrW'(NRows);
  localparam logic [VrW-1:0] HR         = VrW'(H);
  localparam logic [VrW-1:0] H2R        = VrW'(2 * H);
  localparam logic [VcW-1:0] LastCol    = VcW'(NCols - 1);
  localparam logic [VcW-1:0] LastColPad = VcW'(NCols - 1 + H);
  localparam logic [VcW-1:0] NumCols    = VcW'(NCols);
  localparam logic [VcW-1:0] HC         = VcW'(H);
  localparam logic [VcW-1:0] H2C        = VcW'(2 * H);

  // Window index (0..MASK_WIDTH-1) that supplies tap k for centre ctr along one axis.
  function automatic int map_tap(input int ctr, input int k, input int n, input logic [1:0] mode);
    int p, q;
    p = ctr - H + k;
    q = p;
    if (p < 0) q = (mode == BM_MIRR) ? -p : 0;
    else if (p > n - 1) q = (mode == BM_MIRR) ? 2 * (n - 1) - p : n - 1;
    return q - (ctr - H);
  endfunction

  state_e           state_q, state_d;
  logic [VrW-1:0]   vr_q, vr_d, pos_r, last_r;
  logic [VcW-1:0]   vc_q, vc_d, pos_c, last_c;
  logic [1:0]       mode_q, mode_d, mode_eff;
  logic             ready_q, ready_d;
  logic             acc, sof_acc, adv, done, emit, padded;
  logic             win_valid_q, frame_done_q;
  logic [WinW-1:0]  win_pix_q, win_sub;
  logic [RowW-1:0]  win_row_q;
  logic [ColW-1:0]  win_col_q;

  logic [MASK_WIDTH*PIX_BIT-1:0] col_pix;
  logic [PIX_BIT-1:0] hist_q   [MASK_WIDTH][MASK_WIDTH-1];
  logic [PIX_BIT-1:0] win_next [MASK_WIDTH][MASK_WIDTH];
  logic [IdxW-1:0]    ri [MASK_WIDTH];
  logic [IdxW-1:0]    cj [MASK_WIDTH];
  logic               row_oob [MASK_WIDTH];
  logic               col_oob [MASK_WIDTH];
  int                 cr, cc;

  always_comb begin
    acc      = pix_in_valid & ready_q;
    sof_acc  = acc & sof;
    mode_eff = sof_acc ? border_mode : mode_q;
    mode_d   = mode_eff;
    padded   = (mode_eff != BM_NONE);
    pos_r    = sof_acc ? '0 : vr_q;
    pos_c    = sof_acc ? '0 : vc_q;
    last_r   = padded ? LastRowPad : LastRow;
    last_c   = padded ? LastColPad : LastCol;
    // Bubbles (ready low while busy) advance every cycle without a pixel.
    adv  = sof_acc | (acc & (state_q == StRun)) | ((state_q != StIdle) & ~ready_q);
    done = adv & (pos_r == last_r) & (pos_c == last_c);
    emit = adv & (padded ? ((pos_r >= HR) & (pos_c >= HC)) : ((pos_r >= H2R) & (pos_c >= H2C)));
    state_d = state_q;
    vr_d    = vr_q;
    vc_d    = vc_q;
    if (adv) begin
      if (pos_c == last_c) begin
        vc_d = '0;
        vr_d = pos_r + VrW'(1);
      end else begin
        vc_d = pos_c + VcW'(1);
        vr_d = pos_r;
      end
      if (done) begin
        state_d = StIdle;
        vr_d    = '0;
        vc_d    = '0;
      end else if (vr_d >= NumRows) begin
        state_d = StFlush;
      end else begin
        state_d = StRun;
      end
    end
    ready_d = (state_d == StIdle) | ((state_d == StRun) & (vc_d < NumCols));
  end

  row_buffers_param #(
    .ROW_WIDTH (ROW_WIDTH),
    .PIX_BIT   (PIX_BIT),
    .MASK_WIDTH(MASK_WIDTH)
  ) u_row_buffers (
    .clk    (clk),
    .reset  (reset),
    .restart(sof_acc),
    .adv    (adv & (pos_c < NumCols)),
    .we     (adv & ready_q),
    .din    (pix_in),
    .col_pix(col_pix)
  );

  always_comb begin
    for (int i = 0; i < int'(MASK_WIDTH); i++) begin
      for (int j = 0; j < int'(MASK_WIDTH) - 1; j++) win_next[i][j] = hist_q[i][j];
      win_next[i][MASK_WIDTH-1] = col_pix[i*PIX_BIT +: PIX_BIT];
    end
  end

  // Out-of-image taps are rebuilt from in-window data; rows and columns map independently.
  always_comb begin
    cr = int'(pos_r) - H;
    cc = int'(pos_c) - H;
    for (int k = 0; k < int'(MASK_WIDTH); k++) begin
      row_oob[k] = (cr - H + k < 0) || (cr - H + k > NRows - 1);
      col_oob[k] = (cc - H + k < 0) || (cc - H + k > NCols - 1);
      ri[k]      = IdxW'(map_tap(cr, k, NRows, mode_eff));
      cj[k]      = IdxW'(map_tap(cc, k, NCols, mode_eff));
    end
    for (int i = 0; i < int'(MASK_WIDTH); i++) begin
      for (int j = 0; j < int'(MASK_WIDTH); j++) begin
        win_sub[(i*int'(MASK_WIDTH)+j)*int'(PIX_BIT) +: PIX_BIT] =
            ((mode_eff == BM_ZERO) && (row_oob[i] || col_oob[j])) ? '0 : win_next[ri[i]][cj[j]];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      vr_q         <= '0;
      vc_q         <= '0;
      mode_q       <= BM_NONE;
      ready_q      <= 1'b1;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_pix_q    <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      for (int i = 0; i < int'(MASK_WIDTH); i++) begin
        for (int j = 0; j < int'(MASK_WIDTH) - 1; j++) hist_q[i][j] <= '0;
      end
    end else begin
      state_q      <= state_d;
      vr_q         <= vr_d;
      vc_q         <= vc_d;
      mode_q       <= mode_d;
      ready_q      <= ready_d;
      win_valid_q  <= emit;
      frame_done_q <= done;
      if (adv) begin
        for (int i = 0; i < int'(MASK_WIDTH); i++) begin
          for (int j = 0; j < int'(MASK_WIDTH) - 1; j++) hist_q[i][j] <= win_next[i][j+1];
        end
      end
      if (emit) begin
        win_pix_q <= win_sub;
        win_row_q <= RowW'(pos_r - HR);
        win_col_q <= ColW'(pos_c - HC);
      end
    end
  end

  assign pix_in_ready = ready_q;
  assign win_valid    = win_valid_q;
  assign win_pix      = win_pix_q;
  assign win_row      = win_row_q;
  assign win_col      = win_col_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_sliding_window_border.sv
// Directed bench for sliding_window_border on an 8x6 frame with a 3x3 window,
// pixel(r,c) = base + r*16 + c.
module tb_sliding_window_border;

  localparam int RW = 8;
  localparam int CH = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  border_mode;
  logic        sof;
  logic        pix_in_valid;
  logic [7:0]  pix_in;
  logic        pix_in_ready;
  logic        win_valid;
  logic [71:0] win_pix;
  logic [2:0]  win_row;
  logic [2:0]  win_col;
  logic        frame_done;

  sliding_window_border #(
    .ROW_WIDTH (RW),
    .COL_HEIGHT(CH),
    .PIX_BIT   (8),
    .MASK_WIDTH(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .border_mode (border_mode),
    .sof         (sof),
    .pix_in_valid(pix_in_valid),
    .pix_in      (pix_in),
    .pix_in_ready(pix_in_ready),
    .win_valid   (win_valid),
    .win_pix     (win_pix),
    .win_row     (win_row),
    .win_col     (win_col),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int acc18_cyc = -1;
  int ready_low = 0;
  int stray_fd = 0;
  bit count_ready = 1'b0;

  logic [2:0]  q_row[$];
  logic [2:0]  q_col[$];
  logic [71:0] q_pix[$];
  bit          q_fd[$];
  int          q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (win_valid) begin
      q_row.push_back(win_row);
      q_col.push_back(win_col);
      q_pix.push_back(win_pix);
      q_fd.push_back(frame_done);
      q_cyc.push_back(cyc);
    end else if (frame_done) begin
      stray_fd++;
    end
    if (count_ready && !pix_in_ready) ready_low++;
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] tap(input logic [71:0] w, input int t);
    return w[t*8 +: 8];
  endfunction

  // Reference window: every tap from image coordinates with border substitution.
  function automatic logic [71:0] exp_win(input logic [1:0] mode, input logic [7:0] base,
                                          input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int rr, cc;
        bit z;
        rr = r - 1 + i;
        cc = c - 1 + j;
        z  = 1'b0;
        if (rr < 0 || rr > CH - 1) begin
          if (mode == 2'd1) z = 1'b1;
          else if (mode == 2'd2) rr = (rr < 0) ? 0 : CH - 1;
          else rr = (rr < 0) ? -rr : 2 * (CH - 1) - rr;
        end
        if (cc < 0 || cc > RW - 1) begin
          if (mode == 2'd1) z = 1'b1;
          else if (mode == 2'd2) cc = (cc < 0) ? 0 : RW - 1;
          else cc = (cc < 0) ? -cc : 2 * (RW - 1) - cc;
        end
        w[(i*3+j)*8 +: 8] = z ? 8'h00 : 8'(int'(base) + rr * 16 + cc);
      end
    end
    return w;
  endfunction

  task automatic clear_caps();
    #1;
    q_row.delete();
    q_col.delete();
    q_pix.delete();
    q_fd.delete();
    q_cyc.delete();
  endtask

  task automatic send_frame(input string nm, input logic [1:0] mode, input logic [7:0] base,
                            input int npix, input bit gaps);
    int k;
    int budget;
    bit acc;
    k = 0;
    budget = 0;
    while (k < npix && budget < 2000) begin
      @(negedge clk);
      pix_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pix_in       = 8'(int'(base) + (k / RW) * 16 + (k % RW));
      sof          = (k == 0);
      border_mode  = (k == 0) ? mode : 2'(k + 1);
      acc          = pix_in_valid && pix_in_ready;
      if (acc && k == 18) acc18_cyc = cyc + 1;
      @(posedge clk);
      if (acc) k++;
      budget++;
    end
    check({nm, "_sent"}, 72'(k), 72'(npix));
    @(negedge clk);
    pix_in_valid = 1'b0;
    sof          = 1'b0;
  endtask

  task automatic check_frame(input string nm, input logic [1:0] mode, input logic [7:0] base);
    int r0, r1, c0, c1, idx;
    r0 = (mode == 2'd0) ? 1 : 0;
    r1 = (mode == 2'd0) ? CH - 2 : CH - 1;
    c0 = (mode == 2'd0) ? 1 : 0;
    c1 = (mode == 2'd0) ? RW - 2 : RW - 1;
    check({nm, "_count"}, 72'(q_pix.size()), 72'((r1 - r0 + 1) * (c1 - c0 + 1)));
    idx = 0;
    for (int r = r0; r <= r1; r++) begin
      for (int c = c0; c <= c1; c++) begin
        if (idx < q_pix.size()) begin
          check({nm, "_centre"}, 72'({q_row[idx], q_col[idx]}), 72'({3'(r), 3'(c)}));
          check({nm, "_pix"}, q_pix[idx], exp_win(mode, base, r, c));
          check({nm, "_fd"}, 72'(q_fd[idx]), 72'(r == r1 && c == c1));
        end
        idx++;
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    border_mode  = 2'd0;
    sof          = 1'b0;
    pix_in_valid = 1'b0;
    pix_in       = 8'h00;
    #3;
    check("rst_win_valid", 72'(win_valid), 72'(0));
    check("rst_ready", 72'(pix_in_ready), 72'(1));
    check("rst_frame_done", 72'(frame_done), 72'(0));
    check("rst_centre", 72'({win_row, win_col}), 72'(0));
    @(negedge clk);
    reset = 1'b0;

    // Mode 0: interior windows only.
    clear_caps();
    send_frame("m0", 2'd0, 8'h00, 48, 1'b0);
    repeat (20) @(negedge clk);
    check_frame("m0", 2'd0, 8'h00);
    check("m0_latency", 72'(q_cyc.size() > 0 ? q_cyc[0] : -1), 72'(acc18_cyc));
    check("m0_tap00", 72'(tap(q_pix.size() > 0 ? q_pix[0] : '1, 0)), 72'(8'h00));
    check("m0_tap11", 72'(tap(q_pix.size() > 0 ? q_pix[0] : '1, 4)), 72'(8'h11));
    check("m0_tap22", 72'(tap(q_pix.size() > 0 ? q_pix[0] : '1, 8)), 72'(8'h22));

    // Mode 1: zero pad, and count ready-low cycles.
    clear_caps();
    ready_low   = 0;
    count_ready = 1'b1;
    send_frame("m1", 2'd1, 8'h00, 48, 1'b0);
    repeat (20) @(negedge clk);
    count_ready = 1'b0;
    check("m1_ready_low", 72'(ready_low), 72'(CH + RW + 1));
    check_frame("m1", 2'd1, 8'h00);
    if (q_pix.size() > 0) begin
      check("m1_tap00", 72'(tap(q_pix[0], 0)), 72'(8'h00));
      check("m1_tap02", 72'(tap(q_pix[0], 2)), 72'(8'h00));
      check("m1_tap20", 72'(tap(q_pix[0], 6)), 72'(8'h00));
      check("m1_tap22", 72'(tap(q_pix[0], 8)), 72'(8'h11));
    end

    // Mode 2: replicate, bottom-right corner centre (5,7).
    clear_caps();
    send_frame("m2", 2'd2, 8'h00, 48, 1'b0);
    repeat (20) @(negedge clk);
    check_frame("m2", 2'd2, 8'h00);
    if (q_pix.size() == 48) begin
      check("m2_tap22", 72'(tap(q_pix[47], 8)), 72'(8'h57));
      check("m2_tap00", 72'(tap(q_pix[47], 0)), 72'(8'h46));
      check("m2_tap20", 72'(tap(q_pix[47], 6)), 72'(8'h56));
      check("m2_tap02", 72'(tap(q_pix[47], 2)), 72'(8'h47));
    end

    // Mode 3: mirror, top-left centre (0,0).
    clear_caps();
    send_frame("m3", 2'd3, 8'h00, 48, 1'b0);
    repeat (20) @(negedge clk);
    check_frame("m3", 2'd3, 8'h00);
    if (q_pix.size() > 0) begin
      check("m3_tap00", 72'(tap(q_pix[0], 0)), 72'(8'h11));
      check("m3_tap01", 72'(tap(q_pix[0], 1)), 72'(8'h10));
      check("m3_tap10", 72'(tap(q_pix[0], 3)), 72'(8'h01));
      check("m3_tap22", 72'(tap(q_pix[0], 8)), 72'(8'h11));
    end

    // Mode 3 with random valid gaps.
    clear_caps();
    send_frame("m3g", 2'd3, 8'h00, 48, 1'b1);
    repeat (20) @(negedge clk);
    check_frame("m3g", 2'd3, 8'h00);

    // Asynchronous reset while a window is being presented.
    clear_caps();
    send_frame("rst", 2'd1, 8'h00, 30, 1'b0);
    check("pre_reset_win_valid", 72'(win_valid), 72'(1));
    #2 reset = 1'b1;
    #1;
    check("async_win_valid", 72'(win_valid), 72'(0));
    check("async_frame_done", 72'(frame_done), 72'(0));
    check("async_ready", 72'(pix_in_ready), 72'(1));
    @(negedge clk);
    reset = 1'b0;

    // sof mid-frame aborts the old frame.
    clear_caps();
    send_frame("old", 2'd1, 8'h80, 20, 1'b0);
    clear_caps();
    send_frame("new", 2'd1, 8'h00, 48, 1'b0);
    repeat (20) @(negedge clk);
    check_frame("abort", 2'd1, 8'h00);
    check("stray_frame_done", 72'(stray_fd), 72'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
